// File: rtl/fetch_ctrl_if.sv
// Fetch-controller bus bundle: PC handshake, instruction-memory request/response
// and decode-side valid/ready. The master modport is the fetch controller; the
// slave modport is its environment (PC register, instruction memory, decode).
interface fetch_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] PC_i;
  logic                  PCEn_o;
  logic                  flush_i;
  logic                  ImemReq_o;
  logic [DATA_WIDTH-1:0] ImemAddr_o;
  logic                  ImemRvalid_i;
  logic [DATA_WIDTH-1:0] ImemRdata_i;
  logic [DATA_WIDTH-1:0] Instr_o;
  logic [DATA_WIDTH-1:0] InstrPC_o;
  logic                  InstrValid_o;
  logic                  DecReady_i;
  logic                  BusErr_o;

  modport master (
    input  PC_i, flush_i, ImemRvalid_i, ImemRdata_i, DecReady_i,
    output PCEn_o, ImemReq_o, ImemAddr_o, Instr_o, InstrPC_o, InstrValid_o, BusErr_o
  );

  modport slave (
    output PC_i, flush_i, ImemRvalid_i, ImemRdata_i, DecReady_i,
    input  PCEn_o, ImemReq_o, ImemAddr_o, Instr_o, InstrPC_o, InstrValid_o, BusErr_o
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: issues one instruction-memory request at a time for the
// current PC, hands the response to decode through a valid/ready output
// register backed by a one-entry skid, advances the PC on each handoff and
// discards in-flight responses on a redirect. A sticky flag reports a memory
// that stays silent for TIMEOUT cycles.
module fetch_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  // Timer only needs to reach TIMEOUT-1; the flag is raised on that cycle.
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_req_pc;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_instr_pc;
  logic                  r_valid;
  logic                  r_bus_err;
  logic [TW-1:0]         r_timer;

  state_t w_next;
  logic   w_out_free;
  logic   w_req;
  logic   w_cap_wait;
  logic   w_cap_hold;
  logic   w_capture;
  logic   w_skid_load;
  logic   w_pcen;
  logic   w_waiting;

  // Next-state, request and capture decisions; flush outranks every capture.
  always_comb begin
    w_next      = r_state;
    w_req       = 1'b0;
    w_cap_wait  = 1'b0;
    w_cap_hold  = 1'b0;
    w_skid_load = 1'b0;
    w_out_free  = !r_valid || bus.DecReady_i;
    unique case (r_state)
      S_IDLE: begin
        if (!bus.flush_i && w_out_free) begin
          w_req  = 1'b1;
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.flush_i) begin
          w_next = bus.ImemRvalid_i ? S_IDLE : S_DROP;
        end else if (bus.ImemRvalid_i) begin
          if (w_out_free) begin
            w_cap_wait = 1'b1;
            w_next     = S_IDLE;
          end else begin
            w_skid_load = 1'b1;
            w_next      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.flush_i) begin
          w_next = S_IDLE;
        end else if (w_out_free) begin
          w_cap_hold = 1'b1;
          w_next     = S_IDLE;
        end
      end
      S_DROP: begin
        if (bus.ImemRvalid_i) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    w_capture = w_cap_wait || w_cap_hold;
    w_pcen    = bus.flush_i || w_capture;
    w_waiting = (r_state == S_WAIT || r_state == S_DROP) &&
                (w_next  == S_WAIT || w_next  == S_DROP);
  end

  // Combinational strobes are held low while reset is asserted.
  assign bus.ImemReq_o    = rst_ni && w_req;
  assign bus.PCEn_o       = rst_ni && w_pcen;
  assign bus.ImemAddr_o   = (rst_ni && w_req) ? bus.PC_i : r_req_pc;
  assign bus.Instr_o      = r_instr;
  assign bus.InstrPC_o    = r_instr_pc;
  assign bus.InstrValid_o = r_valid;
  assign bus.BusErr_o     = r_bus_err;

  // FSM state, request PC, skid, output register and timeout tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_req_pc   <= '0;
      r_skid     <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_bus_err  <= 1'b0;
      r_timer    <= '0;
    end else begin
      r_state <= w_next;
      if (w_req) begin
        r_req_pc <= bus.PC_i;
      end
      if (w_skid_load) begin
        r_skid <= bus.ImemRdata_i;
      end
      if (bus.flush_i) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_valid    <= 1'b1;
        r_instr    <= w_cap_hold ? r_skid : bus.ImemRdata_i;
        r_instr_pc <= r_req_pc;
      end else if (bus.DecReady_i) begin
        r_valid <= 1'b0;
      end
      if (w_waiting) begin
        if (r_timer == TLIM) begin
          r_bus_err <= 1'b1;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end else begin
        r_timer <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: an environment (PC register, variable-latency memory,
// decode) plus a transaction-level reference of what decode must see, driven
// by directed steps followed by randomized traffic.
module tb_fetch_ctrl;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;

  always #5 clk_i = ~clk_i;

  fetch_ctrl_if #(.DATA_WIDTH(32)) bus ();

  fetch_ctrl #(
    .DATA_WIDTH(32),
    .TIMEOUT   (8)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus.master)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } item_t;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;
  int unsigned n_cyc = 0;

  // Expected decode stream: fetched, not-yet-accepted instructions in order.
  item_t       sb[$];
  logic [31:0] log_pc[$];

  // Environment state.
  logic [31:0] pc_reg     = '0;
  logic [31:0] exp_addr   = '0;
  logic        exp_err    = 1'b0;
  logic        mem_busy   = 1'b0;
  logic        mem_killed = 1'b0;
  logic [31:0] mem_addr   = '0;
  logic [31:0] mem_data   = '0;
  int          mem_cnt    = 0;

  // Stimulus knobs.
  logic        drv_flush  = 1'b0;
  logic        drv_ready  = 1'b0;
  logic [31:0] flush_tgt  = '0;
  int          lat        = 1;
  logic        no_resp    = 1'b0;
  logic        force_en   = 1'b0;
  logic [31:0] force_data = '0;

  // Snapshot of DUT outputs at the sample point.
  logic        s_req, s_pcen, s_valid, s_err, s_rvalid;
  logic [31:0] s_addr, s_instr, s_ipc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni           = 1'b0;
    bus.flush_i      = 1'b1;
    bus.DecReady_i   = 1'b1;
    bus.PC_i         = 32'hDEAD_BEEC;
    bus.ImemRvalid_i = 1'b1;
    bus.ImemRdata_i  = 32'hFFFF_FFFF;
    #1;
    chk("rst_req",   32'(bus.ImemReq_o), 0);
    chk("rst_pcen",  32'(bus.PCEn_o), 0);
    chk("rst_valid", 32'(bus.InstrValid_o), 0);
    chk("rst_err",   32'(bus.BusErr_o), 0);
    chk("rst_instr", bus.Instr_o, 0);
    chk("rst_ipc",   bus.InstrPC_o, 0);
    chk("rst_addr",  bus.ImemAddr_o, 0);
    sb.delete();
    pc_reg   = '0;
    exp_addr = '0;
    exp_err  = 1'b0;
    mem_busy = 1'b0;
    no_resp  = 1'b0;
    drv_flush = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // One clock: drive at posedge+1, sample/check/update at negedge, advance PC at posedge.
  task automatic cycle();
    bus.flush_i    = drv_flush;
    bus.DecReady_i = drv_ready;
    bus.PC_i       = pc_reg;
    if (mem_busy && mem_cnt == 0 && !no_resp) begin
      bus.ImemRvalid_i = 1'b1;
      bus.ImemRdata_i  = mem_data;
    end else begin
      bus.ImemRvalid_i = 1'b0;
      bus.ImemRdata_i  = $urandom;
    end
    @(negedge clk_i);
    s_req    = bus.ImemReq_o;
    s_addr   = bus.ImemAddr_o;
    s_pcen   = bus.PCEn_o;
    s_valid  = bus.InstrValid_o;
    s_instr  = bus.Instr_o;
    s_ipc    = bus.InstrPC_o;
    s_err    = bus.BusErr_o;
    s_rvalid = bus.ImemRvalid_i;
    n_cyc++;

    chk("bus_err", 32'(s_err), 32'(exp_err));
    chk("instr_valid", 32'(s_valid), 32'(sb.size() != 0));
    if (s_valid && sb.size() != 0) begin
      chk("instr_data", s_instr, sb[0].data);
      chk("instr_pc",   s_ipc,   sb[0].pc);
    end
    if (drv_flush) chk("pcen_on_flush", 32'(s_pcen), 1);
    if (mem_busy && !s_rvalid && !drv_flush) chk("pcen_while_outstanding", 32'(s_pcen), 0);
    if (s_req) begin
      chk("single_outstanding", 32'(mem_busy), 0);
      chk("req_addr", s_addr, exp_addr);
    end

    if (s_valid && drv_ready && !drv_flush && sb.size() != 0) begin
      log_pc.push_back(sb[0].pc);
      void'(sb.pop_front());
    end
    if (drv_flush) begin
      sb.delete();
      mem_killed = 1'b1;
      exp_addr   = flush_tgt;
    end
    if (s_rvalid) begin
      if (!mem_killed && !drv_flush) begin
        sb.push_back('{mem_addr, mem_data});
        exp_addr = mem_addr + 32'd4;
      end
      mem_busy = 1'b0;
    end else if (mem_busy && mem_cnt != 0) begin
      mem_cnt--;
    end
    if (s_req) begin
      mem_busy   = 1'b1;
      mem_killed = 1'b0;
      mem_addr   = s_addr;
      mem_data   = force_en ? force_data : $urandom;
      mem_cnt    = lat - 1;
    end

    @(posedge clk_i);
    if (s_pcen) pc_reg = drv_flush ? flush_tgt : pc_reg + 32'd4;
    #1;
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned last_req;
    int unsigned nreq;
    logic [31:0] held;
    logic [31:0] exp_log[3];

    #2;
    do_reset();

    // Basic fetch: request in the first cycle, response one cycle later.
    drv_ready  = 1'b1;
    lat        = 1;
    force_en   = 1'b1;
    force_data = 32'h0050_0093;
    cycle();
    chk("t1_req", 32'(s_req), 1);
    chk("t1_addr", s_addr, 0);
    chk("t1_pcen_idle", 32'(s_pcen), 0);
    force_en = 1'b0;
    cycle();
    chk("t1_pcen_capture", 32'(s_pcen), 1);
    lat = 3;
    cycle();
    chk("t1_valid", 32'(s_valid), 1);
    chk("t1_instr", s_instr, 32'h0050_0093);
    chk("t1_ipc", s_ipc, 0);
    chk("t1_pcen_pulse", 32'(s_pcen), 0);
    chk("t1_next_req", 32'(s_req), 1);
    last_req = n_cyc;

    // Latency 3: one request every 4 cycles, PCs delivered in order.
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_req) begin
        chk("t2_req_gap", n_cyc - last_req, 4);
        last_req = n_cyc;
        nreq++;
      end
    end
    chk("t2_req_count", nreq, 3);
    chk("t2_log_len", 32'(log_pc.size() >= 3), 1);
    exp_log = '{32'd0, 32'd4, 32'd8};
    for (int k = 0; k < 3; k++) begin
      if (k < log_pc.size()) chk("t2_pc_order", log_pc[k], exp_log[k]);
    end

    // Decode stalls: output held, no request and no PC advance until ready.
    drv_ready = 1'b0;
    repeat (6) cycle();
    held = s_instr;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_no_req", 32'(s_req), 0);
      chk("t3_no_pcen", 32'(s_pcen), 0);
      chk("t3_held_valid", 32'(s_valid), 1);
      chk("t3_held_instr", s_instr, held);
    end
    drv_ready = 1'b1;
    lat       = 3;
    cycle();
    chk("t3_release_req", 32'(s_req), 1);
    chk("t3_release_pcen", 32'(s_pcen), 0);

    // Flush while waiting: response dropped, refetch from the redirect target.
    flush_tgt = 32'h0000_0100;
    drv_flush = 1'b1;
    cycle();
    chk("t4_flush_pcen", 32'(s_pcen), 1);
    drv_flush = 1'b0;
    cycle();
    chk("t4_valid_cleared", 32'(s_valid), 0);
    chk("t4_no_req_in_drop", 32'(s_req), 0);
    cycle();
    chk("t4_late_rvalid", 32'(s_rvalid), 1);
    chk("t4_drop_no_pcen", 32'(s_pcen), 0);
    lat = 2;
    cycle();
    chk("t4_refetch_req", 32'(s_req), 1);
    chk("t4_refetch_addr", s_addr, 32'h0000_0100);
    cycle();
    flush_tgt = 32'h0000_0200;
    drv_flush = 1'b1;
    cycle();
    chk("t4b_same_cycle_rvalid", 32'(s_rvalid), 1);
    chk("t4b_flush_pcen", 32'(s_pcen), 1);
    drv_flush = 1'b0;
    cycle();
    chk("t4b_refetch_req", 32'(s_req), 1);
    chk("t4b_refetch_addr", s_addr, 32'h0000_0200);
    chk("t4b_valid", 32'(s_valid), 0);

    // Silent memory: flag after 8 waiting cycles, sticky; async reset clears.
    no_resp = 1'b1;
    exp_err = 1'b0;
    repeat (8) cycle();
    exp_err = 1'b1;
    cycle();
    chk("t5_err_set", 32'(s_err), 1);
    repeat (3) cycle();
    do_reset();
    drv_ready = 1'b1;
    lat       = 1;
    cycle();
    chk("t5_post_reset_req", 32'(s_req), 1);
    chk("t5_post_reset_addr", s_addr, 0);

    // Randomized traffic against the stream reference.
    for (int i = 0; i < 800; i++) begin
      drv_ready = ($urandom_range(0, 3) != 0);
      drv_flush = ($urandom_range(0, 9) == 0);
      flush_tgt = 32'($urandom_range(0, 4095)) << 2;
      lat       = int'($urandom_range(1, 5));
      cycle();
    end
    drv_flush = 1'b0;
    drv_ready = 1'b1;
    repeat (10) cycle();
    chk("sb_backlog", 32'(sb.size() <= 1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
